// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// State encoding and doubleword width used by the FSM and storage.
package data_mem_responder_pkg;

    localparam int DW    = 64;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_byte_mem_array.sv
// Byte-addressed little-endian storage: synchronous doubleword write,
// combinational doubleword read at any byte offset.
module byte_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 8; i++) begin
            rdata_o[8*i +: 8] = mem_q[addr_i + AW'(i)];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multicycle data memory responder: one request in flight, fixed
// access latency, response held until the initiator accepts it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DW-1:0]     resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_OK =
        ADDR_W'(DEPTH_BYTES - 8);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     wdata_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DW-1:0]     rdata_q;
    logic              err_q;

    logic              err_d;
    logic [DW-1:0]     rdata_d;
    logic [DW-1:0]     mem_rdata;
    logic              mem_we;
    logic              access;

    // No wrap: any start past the last full doubleword is an error
    assign err_d   = addr_q > LAST_OK;
    assign access  = (state_q == ST_BUSY) && (cnt_q == '0);
    assign mem_we  = access && write_q && !err_d;
    assign rdata_d = (err_d || write_q) ? '0 : mem_rdata;

    byte_mem_array #(
        .DEPTH (DEPTH_BYTES)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        rdata_q      <= rdata_d;
                        err_q        <= err_d;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-array reference
// model and a per-cycle response checker.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 512;

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        int          acc;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;

    logic [7:0] mm [DEPTH];
    req_t pend[$];
    int   acc_log[$];
    int   hs_log[$];
    logic        have_exp = 1'b0;
    logic [63:0] exp_rd;
    logic        exp_err;

    data_mem_responder #(
        .DEPTH_BYTES (DEPTH),
        .LATENCY     (LAT),
        .ADDR_W      (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        ntotal++;
        if (act !== exp)
            $display("FAIL %s: got %h required %h", name, act, exp);
        else
            npass++;
    endtask

    // Reference: flat byte array, range check from the address rule
    function automatic void model(input req_t r, output logic [63:0] rd,
                                  output logic e);
        rd = '0;
        e  = 1'b0;
        if (r.a > 64'(DEPTH - 8)) begin
            e = 1'b1;
        end else if (r.w) begin
            for (int i = 0; i < 8; i++) mm[int'(r.a) + i] = r.d[8*i +: 8];
        end else begin
            for (int i = 0; i < 8; i++) rd[8*i +: 8] = mm[int'(r.a) + i];
        end
    endfunction

    initial forever begin
        req_t r;
        @(negedge clk);
        if (reset) begin
            pend.delete();
            have_exp = 1'b0;
        end else begin
            if (resp_valid) begin
                if (!have_exp) begin
                    if (pend.size() == 0) begin
                        chk("resp_spurious", 64'(resp_valid), 64'd0);
                    end else begin
                        r = pend.pop_front();
                        model(r, exp_rd, exp_err);
                        have_exp = 1'b1;
                        chk("resp_latency", 64'(cyc - r.acc), 64'(LAT + 1));
                    end
                end
                if (have_exp) begin
                    chk("resp_rdata", resp_rdata, exp_rd);
                    chk("resp_err", 64'(resp_err), 64'(exp_err));
                end
                chk("rdy_in_resp", 64'(req_ready), 64'd0);
                if (resp_ready) begin
                    have_exp = 1'b0;
                    hs_log.push_back(cyc);
                end
            end else if (pend.size() > 0) begin
                chk("rdy_in_busy", 64'(req_ready), 64'd0);
            end
            if (req_valid && req_ready) begin
                r.w = req_write;
                r.a = req_addr;
                r.d = req_wdata;
                r.acc = cyc;
                pend.push_back(r);
                acc_log.push_back(cyc);
            end
        end
    end

    task automatic send(input logic w, input logic [63:0] a,
                        input logic [63:0] d, output int acc);
        int n = 0;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(req_ready), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic recv(input int hold, output logic [63:0] rd,
                        output logic e, output int vc);
        int n = 0;
        logic [63:0] rd0;
        @(negedge clk);
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("recv_valid", 64'(resp_valid), 64'd1);
        vc  = cyc;
        rd0 = resp_rdata;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, rd0);
            chk("hold_rdy", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        rd = resp_rdata;
        e  = resp_err;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] rd,
                        output logic e);
        int acc, vc;
        send(w, a, d, acc);
        recv(0, rd, e, vc);
    endtask

    initial begin
        logic [63:0] rd;
        logic        e;
        int          acc, vc, n;

        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_before_edge", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 64'(req_ready), 64'd1);

        xact(1'b1, 64'h18, 64'hCAFEBABE_DEADBEEF, rd, e);
        xact(1'b1, 64'h20, 64'hA5A5A5A5_A5A5A5A5, rd, e);
        xact(1'b1, 64'h1F8, 64'h01234567_89ABCDEF, rd, e);

        xact(1'b1, 64'h10, 64'h11223344_55667788, rd, e);
        chk("t1_st_rdata", rd, 64'd0);
        chk("t1_st_err", 64'(e), 64'd0);
        xact(1'b0, 64'h10, 64'd0, rd, e);
        chk("t1_ld", rd, 64'h11223344_55667788);
        chk("t1_ld_err", 64'(e), 64'd0);

        xact(1'b0, 64'h13, 64'd0, rd, e);
        chk("t2_misaligned", rd, 64'hADBEEF11_22334455);

        send(1'b0, 64'h10, 64'd0, acc);
        recv(3, rd, e, vc);
        chk("t3_latency", 64'(vc - acc), 64'd3);
        chk("t3_rdata", rd, 64'h11223344_55667788);

        xact(1'b0, 64'h1FC, 64'd0, rd, e);
        chk("t4_ld_err", 64'(e), 64'd1);
        chk("t4_ld_rdata", rd, 64'd0);
        xact(1'b1, 64'h1FC, 64'hDEADDEAD_DEADDEAD, rd, e);
        chk("t4_st_err", 64'(e), 64'd1);
        xact(1'b0, 64'h1F8, 64'd0, rd, e);
        chk("t4_last_ok", rd, 64'h01234567_89ABCDEF);
        chk("t4_last_ok_err", 64'(e), 64'd0);
        xact(1'b0, 64'h1F9, 64'd0, rd, e);
        chk("t4_first_bad", 64'(e), 64'd1);
        xact(1'b0, 64'hFFFFFFFF_FFFFFFFC, 64'd0, rd, e);
        chk("t4_nowrap", 64'(e), 64'd1);

        send(1'b1, 64'h20, 64'hFFFFFFFF_FFFFFFFF, acc);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_rdy", 64'(req_ready), 64'd0);
        chk("t5_rst_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_idle_rdy", 64'(req_ready), 64'd1);
        chk("t5_idle_valid", 64'(resp_valid), 64'd0);
        xact(1'b0, 64'h20, 64'd0, rd, e);
        chk("t5_unmodified", rd, 64'hA5A5A5A5_A5A5A5A5);

        acc_log.delete();
        hs_log.delete();
        resp_ready = 1'b1;
        req_write = 1'b0;
        req_addr = 64'h1F8;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (acc_log.size() < 4 && n < 200);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("t6_accepts", 64'(acc_log.size()), 64'd4);
        chk("t6_responses", 64'(hs_log.size()), 64'd4);
        if (acc_log.size() == 4 && hs_log.size() == 4) begin
            for (int k = 0; k < 3; k++) begin
                chk("t6_period", 64'(acc_log[k+1] - acc_log[k]), 64'd4);
                chk("t6_rdy_after_hs", 64'(acc_log[k+1] - hs_log[k]),
                    64'd1);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("end_idle", 64'(pend.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
